// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard controller FSM states and the
// architectural zero register.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with increment enable; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, MEM-stage redirects and
// memory-busy freezes, plus saturating debug counters and a timeout flag.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             branch_taken_mem,
  input  logic             jump_mem,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_flush_lwstall,
  output logic             id_flush_branch,
  output logic             ex_flush,
  output logic             pc_redirect,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             timeout_err
);

  localparam int BW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  state_t        state;
  logic          pending;
  logic [BW-1:0] busy_run;
  logic [BW-1:0] run_next;
  logic          lw_hazard;
  logic          redirect;

  assign lw_hazard = id_ex_memread && (id_ex_rt != REG_ZERO) &&
                     ((id_ex_rt == if_id_rs) ||
                      (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  // A redirect seen during a freeze is parked in pending and replayed later.
  assign redirect = branch_taken_mem || jump_mem || pending;

  always_comb begin
    pc_write         = 1'b0;
    if_id_write      = 1'b0;
    if_id_flush      = 1'b0;
    id_flush_lwstall = 1'b0;
    id_flush_branch  = 1'b0;
    ex_flush         = 1'b0;
    pc_redirect      = 1'b0;
    pipe_freeze      = 1'b0;
    if (dmem_busy) begin
      pipe_freeze = 1'b1;
    end else if (redirect) begin
      pc_redirect     = 1'b1;
      pc_write        = 1'b1;
      if_id_flush     = 1'b1;
      id_flush_branch = 1'b1;
      ex_flush        = 1'b1;
    end else if (lw_hazard) begin
      id_flush_lwstall = 1'b1;
    end else begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
    end
  end

  // Length of the busy run including the current cycle, held at MAX_WAIT.
  always_comb begin
    run_next = (state == WAIT) ? busy_run : '0;
    if (run_next != BW'(MAX_WAIT)) begin
      run_next = run_next + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      pending     <= 1'b0;
      busy_run    <= '0;
      timeout_err <= 1'b0;
    end else if (dmem_busy) begin
      state    <= WAIT;
      pending  <= pending || branch_taken_mem || jump_mem;
      busy_run <= run_next;
      if (run_next == BW'(MAX_WAIT)) begin
        timeout_err <= 1'b1;
      end
    end else begin
      state    <= RUN;
      busy_run <= '0;
      if (redirect) begin
        pending <= 1'b0;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (id_flush_lwstall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_redirect),
    .count (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pipe_freeze),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// expected responses from a rule-level reference model.
module tb_hazard_ctrl;

  localparam int CNT_W    = 2;
  localparam int MAX_WAIT = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_ex_memread;
  logic [4:0]       id_ex_rt;
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             if_id_uses_rt;
  logic             branch_taken_mem;
  logic             jump_mem;
  logic             dmem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_flush_lwstall;
  logic             id_flush_branch;
  logic             ex_flush;
  logic             pc_redirect;
  logic             pipe_freeze;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_err;

  hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_ex_memread    (id_ex_memread),
    .id_ex_rt         (id_ex_rt),
    .if_id_rs         (if_id_rs),
    .if_id_rt         (if_id_rt),
    .if_id_uses_rt    (if_id_uses_rt),
    .branch_taken_mem (branch_taken_mem),
    .jump_mem         (jump_mem),
    .dmem_busy        (dmem_busy),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .id_flush_lwstall (id_flush_lwstall),
    .id_flush_branch  (id_flush_branch),
    .ex_flush         (ex_flush),
    .pc_redirect      (pc_redirect),
    .pipe_freeze      (pipe_freeze),
    .stall_cnt        (stall_cnt),
    .flush_cnt        (flush_cnt),
    .wait_cnt         (wait_cnt),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  // ctl = {pc_write, if_id_write, if_id_flush, id_flush_lwstall,
  //        id_flush_branch, ex_flush, pc_redirect, pipe_freeze}
  typedef struct packed {
    logic [7:0] ctl;
    int         stall;
    int         flush;
    int         waitc;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  // Reference model: what the debug registers should hold right now.
  bit m_pending;
  int m_busy_run;
  int m_stall;
  int m_flush;
  int m_wait;
  bit m_tmo;

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic model_reset();
    m_pending  = 1'b0;
    m_busy_run = 0;
    m_stall    = 0;
    m_flush    = 0;
    m_wait     = 0;
    m_tmo      = 1'b0;
  endtask

  // One clock cycle of stimulus; expected response is pushed for the monitor.
  task automatic step(input bit rst, input bit mr, input int ert, input int rs,
                      input int rt, input bit urt, input bit br, input bit jp,
                      input bit busy);
    exp_t e;
    bit   haz;
    bit   redir;
    @(posedge clk);
    #1;
    reset            = rst;
    id_ex_memread    = mr;
    id_ex_rt         = 5'(ert);
    if_id_rs         = 5'(rs);
    if_id_rt         = 5'(rt);
    if_id_uses_rt    = urt;
    branch_taken_mem = br;
    jump_mem         = jp;
    dmem_busy        = busy;
    if (rst) model_reset();
    haz   = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
    redir = br || jp || m_pending;
    if (busy)       e.ctl = 8'b0000_0001;
    else if (redir) e.ctl = 8'b1010_1110;
    else if (haz)   e.ctl = 8'b0001_0000;
    else            e.ctl = 8'b1100_0000;
    e.stall = m_stall;
    e.flush = m_flush;
    e.waitc = m_wait;
    e.tmo   = m_tmo;
    exp_q.push_back(e);
    if (!rst) begin
      if (busy) begin
        m_pending  = m_pending || br || jp;
        m_wait     = sat_inc(m_wait);
        m_busy_run = m_busy_run + 1;
        if (m_busy_run >= MAX_WAIT) m_tmo = 1'b1;
      end else begin
        m_busy_run = 0;
        if (redir) begin
          m_pending = 1'b0;
          m_flush   = sat_inc(m_flush);
        end else if (haz) begin
          m_stall = sat_inc(m_stall);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a response, compare at the falling edge.
  initial begin : monitor
    exp_t       e;
    logic [7:0] act_ctl;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        act_ctl = {pc_write, if_id_write, if_id_flush, id_flush_lwstall,
                   id_flush_branch, ex_flush, pc_redirect, pipe_freeze};
        total += 5;
        if (act_ctl !== e.ctl) begin
          bad++;
          $display("FAIL ctl txn=%0d got=%b want=%b", txn, act_ctl, e.ctl);
        end
        if (int'(stall_cnt) != e.stall || $isunknown(stall_cnt)) begin
          bad++;
          $display("FAIL stall_cnt txn=%0d got=%0d want=%0d", txn, stall_cnt, e.stall);
        end
        if (int'(flush_cnt) != e.flush || $isunknown(flush_cnt)) begin
          bad++;
          $display("FAIL flush_cnt txn=%0d got=%0d want=%0d", txn, flush_cnt, e.flush);
        end
        if (int'(wait_cnt) != e.waitc || $isunknown(wait_cnt)) begin
          bad++;
          $display("FAIL wait_cnt txn=%0d got=%0d want=%0d", txn, wait_cnt, e.waitc);
        end
        if (timeout_err !== e.tmo) begin
          bad++;
          $display("FAIL timeout_err txn=%0d got=%b want=%b", txn, timeout_err, e.tmo);
        end
        $display("txn %0d ctl=%b stall=%0d flush=%0d wait=%0d tmo=%b",
                 txn, act_ctl, stall_cnt, flush_cnt, wait_cnt, timeout_err);
      end
    end
  end

  initial begin : driver
    bit busy_state;
    reset            = 1'b1;
    id_ex_memread    = 1'b0;
    id_ex_rt         = '0;
    if_id_rs         = '0;
    if_id_rt         = '0;
    if_id_uses_rt    = 1'b0;
    branch_taken_mem = 1'b0;
    jump_mem         = 1'b0;
    dmem_busy        = 1'b0;
    model_reset();

    // Reset state and idle RUN outputs
    do_reset();
    idle(2);

    // Load-use on rs, then same with the zero register
    step(0, 1, 5, 5, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // rt match, gated by if_id_uses_rt
    step(0, 1, 7, 1, 7, 0, 0, 0, 0);
    step(0, 1, 7, 1, 7, 1, 0, 0, 0);
    idle(1);

    // Branch coincident with a load-use hazard
    do_reset();
    step(0, 1, 5, 5, 0, 0, 1, 0, 0);
    idle(1);

    // Jump during a three-cycle freeze fires on the first free cycle
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Timeout after MAX_WAIT busy cycles, sticky until reset
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);
    do_reset();
    idle(1);

    // Counter saturation: five stalls
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 3, 3, 0, 0, 0, 0, 0);
      idle(1);
    end

    // Asynchronous reset in the middle of WAIT discards the pending branch
    step(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    do_reset();
    idle(2);

    // Random traffic with runs of busy and occasional resets
    busy_state = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) busy_state = ~busy_state;
      step(($urandom_range(0, 149) == 0),
           $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0),
           busy_state);
    end
    idle(2);

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending responses want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
